tri_sweep_ctrl: RTL

- Programmable triangle-sweep sequencer for the HDMI test-pattern path.
- Generates a bounded up/down ramp between cfg_lo and cfg_hi with a programmable step and rate divider, for a programmed number of periods.
- Uses a start/busy/done handshake; abort is supported.
- Output q feeds pattern/colour generators in place of a free-running full-range triangle counter.

---
 rtl/tri_sweep_ctrl_if.sv | 35 +++
 rtl/tri_sweep_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tri_sweep_ctrl_if.sv
// Handshake and data bundle between a sweep requester and the triangle-sweep sequencer.
// Latency: none, wires only.
// Backpressure: none; start/abort are level-sampled, status outputs are registered pulses/levels.
interface tri_sweep_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 8,
    parameter int PER_W = 8
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] cfg_lo;
    logic [WIDTH-1:0] cfg_hi;
    logic [WIDTH-1:0] cfg_step;
    logic [DIV_W-1:0] cfg_div;
    logic [PER_W-1:0] cfg_periods;
    logic [WIDTH-1:0] q;
    logic             dir_up;
    logic             tick;
    logic             period_end;
    logic             busy;
    logic             done;
    logic             cfg_err;

    // Requester side: drives commands and config, observes the ramp.
    modport master (
        output start, abort, cfg_lo, cfg_hi, cfg_step, cfg_div, cfg_periods,
        input  q, dir_up, tick, period_end, busy, done, cfg_err
    );

    // Sequencer side.
    modport slave (
        input  start, abort, cfg_lo, cfg_hi, cfg_step, cfg_div, cfg_periods,
        output q, dir_up, tick, period_end, busy, done, cfg_err
    );
endinterface

// File: rtl/tri_sweep_ctrl.sv
// Bounded up/down triangle ramp between lo and hi, stepping once every div+1 cycles, for N periods.
// Latency: q=lo one cycle after an accepted start; first step at start edge + 2 + div.
// Backpressure: none; start ignored while busy, abort returns to IDLE on the next edge.
module tri_sweep_ctrl #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 8,
    parameter int PER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    tri_sweep_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_FALL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic             dir_up_q;
    logic             tick_q;
    logic             period_end_q;
    logic             busy_q;
    logic             done_q;
    logic             cfg_err_q;

    // Prescaler counts 0..div; fire_q marks the cycle whose closing edge applies a step.
    logic [DIV_W-1:0] presc_q;
    logic             fire_q;
    logic [PER_W-1:0] per_cnt_q;

    // Configuration captured at an IDLE start.
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] step_q;
    logic [DIV_W-1:0] div_q;
    logic [PER_W-1:0] periods_q;

    // Step arithmetic: the rising sum carries an extra bit so a clamp at all-ones cannot wrap,
    // and the falling distance is taken from lo so q never underflows below it.
    logic [WIDTH:0]   rise_sum_d;
    logic             rise_hit_d;
    logic [WIDTH-1:0] fall_dist_d;
    logic             fall_hit_d;
    logic [PER_W-1:0] per_cnt_d;
    logic             last_period_d;
    logic             cfg_bad_d;

    assign rise_sum_d    = {1'b0, q_q} + {1'b0, step_q};
    assign rise_hit_d    = rise_sum_d >= {1'b0, hi_q};
    assign fall_dist_d   = q_q - lo_q;
    assign fall_hit_d    = fall_dist_d <= step_q;
    assign per_cnt_d     = (&per_cnt_q) ? per_cnt_q : per_cnt_q + PER_W'(1);
    assign last_period_d = (periods_q != '0) && (per_cnt_d == periods_q);
    assign cfg_bad_d     = (bus.cfg_lo >= bus.cfg_hi) || (bus.cfg_step == '0);

    // Sequencer state, prescaler, period counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            q_q          <= '0;
            dir_up_q     <= 1'b1;
            tick_q       <= 1'b0;
            period_end_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            presc_q      <= '0;
            fire_q       <= 1'b0;
            per_cnt_q    <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            step_q       <= '0;
            div_q        <= '0;
            periods_q    <= '0;
        end else begin
            tick_q       <= 1'b0;
            period_end_q <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        lo_q      <= bus.cfg_lo;
                        hi_q      <= bus.cfg_hi;
                        step_q    <= bus.cfg_step;
                        div_q     <= bus.cfg_div;
                        periods_q <= bus.cfg_periods;
                        if (cfg_bad_d) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            q_q       <= bus.cfg_lo;
                            dir_up_q  <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_RISE;
                            presc_q   <= '0;
                            fire_q    <= 1'b0;
                            per_cnt_q <= '0;
                        end
                    end
                end

                S_RISE, S_FALL: begin
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        presc_q <= '0;
                        fire_q  <= 1'b0;
                    end else begin
                        if (presc_q == div_q) begin
                            presc_q <= '0;
                            fire_q  <= 1'b1;
                        end else begin
                            presc_q <= presc_q + DIV_W'(1);
                            fire_q  <= 1'b0;
                        end

                        if (fire_q) begin
                            tick_q <= 1'b1;
                            if (state_q == S_RISE) begin
                                if (rise_hit_d) begin
                                    q_q      <= hi_q;
                                    dir_up_q <= 1'b0;
                                    state_q  <= S_FALL;
                                end else begin
                                    q_q <= rise_sum_d[WIDTH-1:0];
                                end
                            end else begin
                                if (fall_hit_d) begin
                                    q_q          <= lo_q;
                                    period_end_q <= 1'b1;
                                    per_cnt_q    <= per_cnt_d;
                                    if (last_period_d) begin
                                        state_q <= S_DONE;
                                        busy_q  <= 1'b0;
                                        presc_q <= '0;
                                        fire_q  <= 1'b0;
                                    end else begin
                                        dir_up_q <= 1'b1;
                                        state_q  <= S_RISE;
                                    end
                                end else begin
                                    q_q <= q_q - step_q;
                                end
                            end
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= !bus.abort;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q          = q_q;
    assign bus.dir_up     = dir_up_q;
    assign bus.tick       = tick_q;
    assign bus.period_end = period_end_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cfg_err    = cfg_err_q;

endmodule
